// File: rtl/axi_sram_slave.sv
// axi_sram_slave
//   Single-beat AXI slave in front of a 32-bit synchronous SRAM with
//   2^ADDR_W words. One transaction is serviced at a time. A read wins
//   over a write that is offered in the same IDLE cycle. Addresses whose
//   bits above the SRAM window are non-zero get SLVERR and no SRAM access.
//
// Ports
//   clk, rst_p            clock, synchronous active-high reset
//   ar*/r*                AXI read address / read data channels
//   aw*/w*/b*             AXI write address / write data / response channels
//   sram_en, sram_wen     SRAM access strobe and byte write enables
//   sram_addr, sram_wdata SRAM word address and write data
//   sram_rdata            SRAM read data, valid the cycle after a read strobe
//
// State table
//   state      | meaning
//   IDLE       | ready for AR, or AW/W when no read is offered
//   RD_REQ     | SRAM read strobe
//   RD_CAP     | capture SRAM read data
//   RD_RESP    | R beat presented, waiting for rready
//   WR_COLLECT | one of AW/W captured, waiting for the other
//   WR_MEM     | SRAM write strobe
//   WR_RESP    | B response presented, waiting for bready
module axi_sram_slave #(
  parameter int ADDR_W = 16
) (
  input  logic              clk,
  input  logic              rst_p,
  input  logic [3:0]        arid,
  input  logic [31:0]       araddr,
  input  logic [7:0]        arlen,
  input  logic [2:0]        arsize,
  input  logic              arvalid,
  output logic              arready,
  output logic [3:0]        rid,
  output logic [31:0]       rdata,
  output logic [1:0]        rresp,
  output logic              rlast,
  output logic              rvalid,
  input  logic              rready,
  input  logic [3:0]        awid,
  input  logic [31:0]       awaddr,
  input  logic [7:0]        awlen,
  input  logic [2:0]        awsize,
  input  logic              awvalid,
  output logic              awready,
  input  logic [3:0]        wid,
  input  logic [31:0]       wdata,
  input  logic [3:0]        wstrb,
  input  logic              wlast,
  input  logic              wvalid,
  output logic              wready,
  output logic [3:0]        bid,
  output logic [1:0]        bresp,
  output logic              bvalid,
  input  logic              bready,
  output logic              sram_en,
  output logic [3:0]        sram_wen,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [31:0]       sram_wdata,
  input  logic [31:0]       sram_rdata
);

  typedef enum logic [2:0] {
    IDLE,
    RD_REQ,
    RD_CAP,
    RD_RESP,
    WR_COLLECT,
    WR_MEM,
    WR_RESP
  } state_t;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  state_t state;

  logic              rd_ok;
  logic              aw_held;
  logic              w_held;
  logic [3:0]        aw_id_q;
  logic [ADDR_W-1:0] aw_addr_q;
  logic              aw_ok_q;
  logic [31:0]       w_data_q;
  logic [3:0]        w_strb_q;

  // Burst/size/id fields that a single-beat slave has no use for.
  logic unused_fields;
  assign unused_fields = ^{arlen, arsize, awlen, awsize, wid, wlast};

  function automatic logic addr_ok(input logic [31:0] a);
    return (a >> (ADDR_W + 2)) == 32'd0;
  endfunction

  // Readies are decoded from the registered state; awready/wready also
  // look at arvalid so a read offered in IDLE blocks the write channels.
  assign arready = !rst_p && (state == IDLE);
  assign awready = !rst_p && (((state == IDLE) && !arvalid) ||
                              ((state == WR_COLLECT) && !aw_held));
  assign wready  = !rst_p && (((state == IDLE) && !arvalid) ||
                              ((state == WR_COLLECT) && !w_held));

  logic aw_hs;
  logic w_hs;
  logic wr_go;
  assign aw_hs = awvalid && awready;
  assign w_hs  = wvalid && wready;
  assign wr_go = (aw_held || aw_hs) && (w_held || w_hs);

  // Write beat as seen on the edge that completes AW+W: a channel captured
  // on this very edge comes straight from the bus.
  logic [ADDR_W-1:0] wr_addr;
  logic              wr_ok;
  logic [31:0]       wr_data;
  logic [3:0]        wr_strb;
  assign wr_addr = aw_held ? aw_addr_q : awaddr[ADDR_W+1:2];
  assign wr_ok   = aw_held ? aw_ok_q   : addr_ok(awaddr);
  assign wr_data = w_held  ? w_data_q  : wdata;
  assign wr_strb = w_held  ? w_strb_q  : wstrb;

  always_ff @(posedge clk) begin
    if (rst_p) begin
      state      <= IDLE;
      rd_ok      <= 1'b0;
      aw_held    <= 1'b0;
      w_held     <= 1'b0;
      aw_id_q    <= '0;
      aw_addr_q  <= '0;
      aw_ok_q    <= 1'b0;
      w_data_q   <= '0;
      w_strb_q   <= '0;
      rid        <= '0;
      rdata      <= '0;
      rresp      <= '0;
      rlast      <= 1'b0;
      rvalid     <= 1'b0;
      bid        <= '0;
      bresp      <= '0;
      bvalid     <= 1'b0;
      sram_en    <= 1'b0;
      sram_wen   <= '0;
      sram_addr  <= '0;
      sram_wdata <= '0;
    end else begin
      if (aw_hs) begin
        aw_held   <= 1'b1;
        aw_id_q   <= awid;
        aw_addr_q <= awaddr[ADDR_W+1:2];
        aw_ok_q   <= addr_ok(awaddr);
      end
      if (w_hs) begin
        w_held   <= 1'b1;
        w_data_q <= wdata;
        w_strb_q <= wstrb;
      end

      case (state)
        IDLE, WR_COLLECT: begin
          if ((state == IDLE) && arvalid) begin
            rid       <= arid;
            rd_ok     <= addr_ok(araddr);
            sram_addr <= araddr[ADDR_W+1:2];
            sram_en   <= addr_ok(araddr);
            sram_wen  <= '0;
            state     <= RD_REQ;
          end else if (wr_go) begin
            sram_addr  <= wr_addr;
            sram_wdata <= wr_data;
            sram_en    <= wr_ok;
            sram_wen   <= wr_ok ? wr_strb : 4'b0000;
            state      <= WR_MEM;
          end else if (aw_hs || w_hs) begin
            state <= WR_COLLECT;
          end
        end
        RD_REQ: begin
          sram_en <= 1'b0;
          state   <= RD_CAP;
        end
        RD_CAP: begin
          rdata  <= rd_ok ? sram_rdata : 32'h0;
          rresp  <= rd_ok ? RESP_OKAY : RESP_SLVERR;
          rlast  <= 1'b1;
          rvalid <= 1'b1;
          state  <= RD_RESP;
        end
        RD_RESP: begin
          if (rready) begin
            rvalid <= 1'b0;
            rlast  <= 1'b0;
            state  <= IDLE;
          end
        end
        WR_MEM: begin
          sram_en  <= 1'b0;
          sram_wen <= '0;
          aw_held  <= 1'b0;
          w_held   <= 1'b0;
          bid      <= aw_id_q;
          bresp    <= aw_ok_q ? RESP_OKAY : RESP_SLVERR;
          bvalid   <= 1'b1;
          state    <= WR_RESP;
        end
        WR_RESP: begin
          if (bready) begin
            bvalid <= 1'b0;
            state  <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_sram_slave.sv
// tb_axi_sram_slave
//   Directed bench for axi_sram_slave. Stimulus pushes the expected R/B
//   response into a queue; a negedge monitor pops and compares whenever a
//   response handshake is presented. A small SRAM model backs the DUT.
module tb_axi_sram_slave;

  logic        clk;
  logic        rst_p;
  logic [3:0]  arid;
  logic [31:0] araddr;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic        arvalid;
  logic        arready;
  logic [3:0]  rid;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rlast;
  logic        rvalid;
  logic        rready;
  logic [3:0]  awid;
  logic [31:0] awaddr;
  logic [7:0]  awlen;
  logic [2:0]  awsize;
  logic        awvalid;
  logic        awready;
  logic [3:0]  wid;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wlast;
  logic        wvalid;
  logic        wready;
  logic [3:0]  bid;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;
  logic        sram_en;
  logic [3:0]  sram_wen;
  logic [15:0] sram_addr;
  logic [31:0] sram_wdata;
  logic [31:0] sram_rdata;

  axi_sram_slave #(.ADDR_W(16)) dut (
    .clk(clk), .rst_p(rst_p),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize),
    .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast),
    .rvalid(rvalid), .rready(rready),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize),
    .awvalid(awvalid), .awready(awready),
    .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast),
    .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .sram_en(sram_en), .sram_wen(sram_wen), .sram_addr(sram_addr),
    .sram_wdata(sram_wdata), .sram_rdata(sram_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // SRAM model; preload runs while the bench holds it in reset.
  logic        preload;
  logic [31:0] mem [0:255];
  always @(posedge clk) begin
    if (preload) begin
      mem[2] <= 32'hAABB_CCDD;
      mem[3] <= 32'h0;
      mem[4] <= 32'hDEAD_BEEF;
      mem[5] <= 32'h0;
    end else if (sram_en) begin
      sram_rdata <= mem[sram_addr[7:0]];
      for (int b = 0; b < 4; b++)
        if (sram_wen[b]) mem[sram_addr[7:0]][8*b +: 8] <= sram_wdata[8*b +: 8];
    end
  end

  typedef struct {
    bit          is_wr;
    logic [3:0]  id;
    logic [1:0]  resp;
    logic [31:0] data;
  } exp_t;

  exp_t exp_q[$];
  exp_t e;
  int   checks = 0;
  int   failures = 0;
  int   en_cnt = 0;
  int   rd_cnt = 0;
  int   aw_hs_rdcnt = 0;
  bit   both_seen = 0;
  logic [15:0] last_addr;
  logic [3:0]  last_wen;
  logic [31:0] last_wdata;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    checks++;
    failures++;
    $display("FAIL %s timeout actual=no_handshake required=handshake", name);
  endtask

  task automatic push_rd(input logic [3:0] id, input logic [31:0] data, input logic [1:0] resp);
    exp_t x;
    x.is_wr = 0; x.id = id; x.resp = resp; x.data = data;
    exp_q.push_back(x);
  endtask

  task automatic push_wr(input logic [3:0] id, input logic [1:0] resp);
    exp_t x;
    x.is_wr = 1; x.id = id; x.resp = resp; x.data = 32'h0;
    exp_q.push_back(x);
  endtask

  // Monitor: scoreboard pops on every R/B handshake.
  always @(negedge clk) begin
    if (!rst_p) begin
      if (rvalid && bvalid) both_seen = 1;
      if (sram_en) begin
        en_cnt++;
        last_addr  = sram_addr;
        last_wen   = sram_wen;
        last_wdata = sram_wdata;
      end
      if (rvalid && rready) begin
        rd_cnt++;
        if (exp_q.size() == 0) begin
          timeout("unexpected_r");
        end else begin
          e = exp_q.pop_front();
          chk("r_beat", {24'h0, 1'b0, rid, rresp, rlast, rdata},
              {24'h0, e.is_wr, e.id, e.resp, !e.is_wr, e.is_wr ? 32'h0 : e.data});
        end
      end
      if (bvalid && bready) begin
        if (exp_q.size() == 0) begin
          timeout("unexpected_b");
        end else begin
          e = exp_q.pop_front();
          chk("b_beat", {24'h0, 1'b1, bid, bresp, 1'b0, 32'h0},
              {24'h0, e.is_wr, e.id, e.resp, !e.is_wr, e.is_wr ? 32'h0 : e.data});
        end
      end
    end
  end

  // Issue tasks are entered just after a rising edge and return just
  // after the handshake edge.
  task automatic ar_issue(input logic [31:0] addr, input logic [3:0] id);
    int n = 0;
    bit ok = 0;
    araddr = addr; arid = id; arvalid = 1'b1;
    while (!ok && n < 100) begin
      @(negedge clk);
      if (arready) ok = 1;
      n++;
    end
    if (ok) @(posedge clk);
    #1 arvalid = 1'b0;
    if (!ok) timeout("ar_handshake");
  endtask

  task automatic aw_issue(input logic [31:0] addr, input logic [3:0] id);
    int n = 0;
    bit ok = 0;
    awaddr = addr; awid = id; awvalid = 1'b1;
    while (!ok && n < 100) begin
      @(negedge clk);
      if (awready) begin
        ok = 1;
        aw_hs_rdcnt = rd_cnt;
      end
      n++;
    end
    if (ok) @(posedge clk);
    #1 awvalid = 1'b0;
    if (!ok) timeout("aw_handshake");
  endtask

  task automatic w_issue(input logic [31:0] data, input logic [3:0] strb);
    int n = 0;
    bit ok = 0;
    wdata = data; wstrb = strb; wvalid = 1'b1;
    while (!ok && n < 100) begin
      @(negedge clk);
      if (wready) ok = 1;
      n++;
    end
    if (ok) @(posedge clk);
    #1 wvalid = 1'b0;
    if (!ok) timeout("w_handshake");
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while ((exp_q.size() != 0 || rvalid || bvalid) && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) timeout(name);
    @(posedge clk);
    #1;
  endtask

  task automatic wait_valid(input bit want_b, input string name);
    int n = 0;
    while (!(want_b ? bvalid : rvalid) && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) timeout(name);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  int          en0;
  int          rd0;
  logic [31:0] snap;
  bit          rv_seen;

  initial begin
    rst_p = 1; preload = 1;
    arid = 0; araddr = 0; arlen = 0; arsize = 3'd2; arvalid = 0;
    awid = 0; awaddr = 0; awlen = 0; awsize = 3'd2; awvalid = 0;
    wid = 0; wdata = 0; wstrb = 0; wlast = 1; wvalid = 0;
    rready = 1; bready = 1;

    // Reset values
    repeat (3) @(posedge clk);
    arvalid = 1'b1;
    @(negedge clk);
    chk("reset_ready", {61'h0, arready, awready, wready}, 64'h0);
    chk("reset_rchan", {22'h0, rvalid, rlast, rid, rresp, rdata}, 64'h0);
    chk("reset_bchan", {57'h0, bvalid, bid, bresp}, 64'h0);
    chk("reset_sram", {11'h0, sram_en, sram_wen, sram_addr, sram_wdata}, 64'h0);
    @(posedge clk);
    #1 rst_p = 0; preload = 0; arvalid = 1'b0;
    @(negedge clk);
    chk("arready_after_reset", {63'h0, arready}, 64'h1);
    @(posedge clk);
    #1;

    // In-range read with exact cycle timing
    push_rd(4'd3, 32'hDEAD_BEEF, 2'b00);
    ar_issue(32'h0000_0010, 4'd3);
    @(negedge clk);
    chk("rd_sram_strobe", {43'h0, sram_en, sram_wen, sram_addr}, {43'h0, 1'b1, 4'h0, 16'd4});
    @(negedge clk);
    chk("rvalid_n2_low", {63'h0, rvalid}, 64'h0);
    @(negedge clk);
    chk("rvalid_n3_high", {63'h0, rvalid}, 64'h1);
    wait_idle("rd_inrange");

    // Write with W one cycle before AW
    en0 = en_cnt;
    push_wr(4'd5, 2'b00);
    w_issue(32'h1234_5678, 4'b0011);
    fork
      aw_issue(32'h0000_0008, 4'd5);
      begin
        @(negedge clk);
        chk("collect_ready", {61'h0, arready, awready, wready}, {61'h0, 3'b010});
      end
    join
    wait_idle("wr_w_first");
    chk("wr_single_strobe", en_cnt - en0, 64'd1);
    chk("wr_sram_fields", {12'h0, last_addr, last_wen, last_wdata},
        {12'h0, 16'd2, 4'b0011, 32'h1234_5678});
    push_rd(4'd3, 32'hAABB_5678, 2'b00);
    ar_issue(32'h0000_0008, 4'd3);
    wait_idle("readback");

    // Simultaneous AR and AW/W: read first, write only after RD_RESP
    rd0 = rd_cnt;
    push_rd(4'd1, 32'hDEAD_BEEF, 2'b00);
    push_wr(4'd6, 2'b00);
    fork
      ar_issue(32'h0000_0010, 4'd1);
      aw_issue(32'h0000_000C, 4'd6);
      w_issue(32'hCAFE_F00D, 4'b1111);
      begin
        @(negedge clk);
        chk("read_wins", {61'h0, arready, awready, wready}, {61'h0, 3'b100});
      end
    join
    wait_idle("simultaneous");
    chk("aw_after_read", aw_hs_rdcnt - rd0, 64'd1);

    // Out-of-range read and write
    en0 = en_cnt;
    push_rd(4'd2, 32'h0, 2'b10);
    ar_issue(32'h0004_0000, 4'd2);
    wait_idle("rd_oor");
    chk("rd_oor_no_strobe", en_cnt - en0, 64'd0);
    en0 = en_cnt;
    push_wr(4'd7, 2'b10);
    fork
      aw_issue(32'h0004_0000, 4'd7);
      w_issue(32'h5555_AAAA, 4'b1111);
    join
    wait_idle("wr_oor");
    chk("wr_oor_no_strobe", en_cnt - en0, 64'd0);

    // Zero strobes in range still perform the memory cycle
    en0 = en_cnt;
    push_wr(4'd4, 2'b00);
    fork
      aw_issue(32'h0000_0010, 4'd4);
      w_issue(32'hFFFF_FFFF, 4'b0000);
    join
    wait_idle("wr_nostrb");
    chk("nostrb_strobe", {11'h0, en_cnt[0 +: 32] - en0[0 +: 32], last_wen, last_addr},
        {11'h0, 32'd1, 4'b0000, 16'd4});
    push_rd(4'd0, 32'hDEAD_BEEF, 2'b00);
    ar_issue(32'h0000_0010, 4'd0);
    wait_idle("nostrb_readback");

    // Read backpressure
    rready = 1'b0;
    push_rd(4'd9, 32'hAABB_5678, 2'b00);
    ar_issue(32'h0000_0008, 4'd9);
    wait_valid(1'b0, "bp_rvalid");
    snap = rdata;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("r_backpressure", {25'h0, rvalid, arready, awready, rid, rdata},
          {25'h0, 3'b100, 4'd9, snap});
    end
    @(posedge clk);
    #1 rready = 1'b1;
    wait_idle("bp_read");

    // Write response backpressure
    bready = 1'b0;
    push_wr(4'd8, 2'b00);
    fork
      aw_issue(32'h0000_0014, 4'd8);
      w_issue(32'h1122_3344, 4'b1111);
    join
    wait_valid(1'b1, "bp_bvalid");
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("b_backpressure", {54'h0, bvalid, arready, awready, wready, bid, bresp},
          {54'h0, 4'b1000, 4'd8, 2'b00});
    end
    @(posedge clk);
    #1 bready = 1'b1;
    wait_idle("bp_write");

    // Reset while in RD_CAP
    ar_issue(32'h0000_0010, 4'd3);
    @(posedge clk);
    #1 rst_p = 1'b1;
    @(posedge clk);
    #1 rst_p = 1'b0;
    @(negedge clk);
    chk("arready_after_midreset", {62'h0, arready, rvalid}, {62'h0, 2'b10});
    rv_seen = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (rvalid) rv_seen = 1;
    end
    chk("no_rvalid_after_abort", {63'h0, rv_seen}, 64'h0);
    chk("scoreboard_drained", exp_q.size(), 64'd0);
    chk("r_b_exclusive", {63'h0, both_seen}, 64'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/axi_sram_slave.md
AXI_SRAM_SLAVE -- requirements
Module: axi_sram_slave

Interface
REQ-001 SHALL have parameter ADDR_W, default 16, giving the SRAM word-address width (2^ADDR_W words of 32 bits).
REQ-002 SHALL have the following ports:
  - clk  in  1  sole clock; all logic is sampled on the rising edge.
  - rst_p  in  1  reset; synchronous, active-high.
  - arid/araddr/arlen/arsize  in  4/32/8/3  read address channel.
  - arvalid  in  1 ; arready  out  1 .
  - rid/rdata/rresp/rlast  out  4/32/2/1  read data channel.
  - rvalid  out  1 ; rready  in  1 .
  - awid/awaddr/awlen/awsize  in  4/32/8/3  write address channel.
  - awvalid  in  1 ; awready  out  1 .
  - wid/wdata/wstrb/wlast  in  4/32/4/1  write data channel.
  - wvalid  in  1 ; wready  out  1 .
  - bid/bresp  out  4/2  write response channel.
  - bvalid  out  1 ; bready  in  1 .
  - sram_en  out  1  SRAM access enable.
  - sram_wen  out  4  byte write enables.
  - sram_addr  out  ADDR_W  word address.
  - sram_wdata  out  32  SRAM write data.
  - sram_rdata  in  32  SRAM read data, valid one cycle after sram_en with sram_wen=0.

Function
REQ-003 SHALL service one transaction at a time, each exactly one beat; arlen, arsize, awlen, awsize, wid and wlast are ignored.
REQ-004 SHALL use the states IDLE, RD_REQ, RD_CAP, RD_RESP, WR_COLLECT, WR_MEM and WR_RESP.
REQ-005 SHALL, in IDLE, assert arready=1, and awready=wready=~arvalid, so that a read wins over a simultaneous write.
REQ-006 SHALL treat an address as in range iff addr[31:ADDR_W+2]==0; sram_addr=addr[ADDR_W+1:2].
REQ-007 SHALL, on the AR handshake (edge N), latch arid, the address and the range flag, and go to RD_REQ.
REQ-008 SHALL, in RD_REQ, drive sram_en=1 (if in range) with sram_wen=0, then go to RD_CAP.
REQ-009 SHALL, in RD_CAP, register sram_rdata (or 0 if out of range), then go to RD_RESP.
REQ-010 SHALL make rvalid first high in cycle N+3, with rlast=1, rid=latched arid, and rresp=00 (in range) or 10 SLVERR (out of range).
REQ-011 SHALL hold rvalid, rdata, rid and rresp stable until rready, then return to IDLE on that edge.
REQ-012 SHALL capture AW and W independently, in either order or together, and hold awready/wready=0 for a channel once it is captured.
REQ-013 SHALL use WR_COLLECT while only one of AW or W has been captured.
REQ-014 SHALL go to WR_MEM on the edge M at which both AW and W are held.
REQ-015 SHALL, in WR_MEM (cycle M+1), drive sram_en=1, sram_wen=wstrb and sram_wdata=wdata, or sram_en=0 and sram_wen=0 if out of range.
REQ-016 SHALL, in WR_RESP (from cycle M+2), assert bvalid with bid=awid and bresp=00 or 10, hold them until bready, then go to IDLE.
REQ-017 SHALL keep sram_en=0 and sram_wen=0 in every state other than RD_REQ and WR_MEM.
REQ-018 SHALL assert arready, awready and wready only in IDLE, or in WR_COLLECT for the channel not yet captured.
REQ-019 SHALL never assert rvalid and bvalid at the same time.
REQ-020 SHALL, with wstrb=0000 and in range, still perform the WR_MEM cycle with sram_wen=0000 and respond OKAY.

Reset
REQ-021 SHALL, while rst_p=1 at a clock edge, enter IDLE and clear all captured AW/W flags, abandoning any in-flight transaction with no response.
REQ-022 SHALL drive the following reset values: arready=awready=wready=0 during reset; rvalid=bvalid=0; rid=bid=0; rresp=bresp=0; rdata=0; rlast=0; sram_en=0; sram_wen=0; sram_addr=0; sram_wdata=0.
REQ-023 SHALL assert arready in the first cycle after rst_p is deasserted.

Verification
REQ-024 SHALL verify in-range read: araddr=0x0000_0010 with arid=3, SRAM word 4 = 0xDEAD_BEEF -> sram_en pulse with sram_addr=4 at N+1; rvalid at N+3 with rdata=0xDEAD_BEEF, rid=3, rresp=00, rlast=1.
REQ-025 SHALL verify write, W one cycle before AW: wdata=0x1234_5678, wstrb=0011, awaddr=0x8 -> a single WR_MEM cycle with sram_addr=2 and sram_wen=0011; then bvalid with bresp=00; a readback of the same address returns the low half updated.
REQ-026 SHALL verify simultaneous arvalid and awvalid in IDLE -> the read completes first, and the write handshakes only after RD_RESP ends.
REQ-027 SHALL verify out-of-range accesses: araddr=0x0004_0000 (ADDR_W=16) -> rresp=10, rdata=0, no sram_en; the same for a write -> bresp=10, no sram_en.
REQ-028 SHALL verify backpressure: rready=0 for 5 cycles -> rvalid and rdata stay stable and no new handshake occurs; the same for bready.
REQ-029 SHALL verify reset mid-operation: rst_p pulsed while in RD_CAP -> rvalid is never asserted, and the next cycle after reset shows arready=1.
